dm_access_stage: RTL

MEM-stage data-memory access unit of the 5-stage RV32I pipeline, between the EX/MEM register and the DM/WB pipeline register. It drives a variable-latency req/ack data-memory port and stalls upstream while an access is outstanding. It aligns store data and byte strobes, sign/zero-extends load data, flags misaligned accesses and bus timeouts, and presents the *_mem signals that DM/WB captures every cycle.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/lsu_align.sv | 65 ++++++
 rtl/dm_access_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the data-memory access stage: load/store
// size encodings and the access FSM state type.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dm_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte replication and strobes, the
// misalign/illegal-size check, and load lane extraction with extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  stOffset,
    input  logic        isStore,
    input  logic [31:0] stData,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        fault,
    input  logic [2:0]  ldFunct3,
    input  logic [1:0]  ldOffset,
    input  logic [31:0] rdata,
    output logic [31:0] loadData
);

    logic [31:0] shifted;

    always_comb begin
        wdata = stData;
        wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{stData[7:0]}};
                wstrb = 4'b0001 << stOffset;
            end
            2'b01: begin
                wdata = {2{stData[15:0]}};
                wstrb = stOffset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = stData;
                wstrb = 4'b1111;
            end
        endcase
    end

    // Unsigned sizes exist only for loads; 011/110/111 are never legal.
    always_comb begin
        fault = 1'b1;
        case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = stOffset[0];
            F3_W:    fault = |stOffset;
            F3_BU:   fault = isStore;
            F3_HU:   fault = isStore | stOffset[0];
            default: fault = 1'b1;
        endcase
    end

    always_comb begin
        shifted  = rdata >> {ldOffset, 3'b000};
        loadData = rdata;
        case (ldFunct3)
            F3_B:    loadData = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    loadData = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   loadData = {24'h0, shifted[7:0]};
            F3_HU:   loadData = {16'h0, shifted[15:0]};
            default: loadData = rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_stage.sv
// MEM-stage data-memory access unit: drives a req/ack memory port, stalls
// upstream while an access is outstanding, and presents DM/WB inputs.
module dm_access_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] rs2Data_in,
    input  logic [4:0]  rdAddr_in,
    output logic        MemtoReg_mem,
    output logic        RegWrite_mem,
    output logic [31:0] MemDout_mem,
    output logic [31:0] ALUResult_mem,
    output logic [4:0]  rdAddr_mem,
    output logic        stall_mem,
    output logic        misalign_mem,
    output logic        bus_err_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output dm_state_t   dbgState
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

    dm_state_t   state, nextState;
    logic [CW-1:0] cnt;
    logic [31:0] capAddr, capWdata, capRdata;
    logic [3:0]  capWstrb;
    logic [2:0]  capFunct3;
    logic [1:0]  capOff;
    logic        capWe, errQ;

    logic        access, fault;
    logic [31:0] alWdata, loadData;
    logic [3:0]  alWstrb;

    assign access   = MemRead_in | MemWrite_in;
    assign dbgState = rst ? IDLE : state;

    lsu_align u_align (
        .funct3   (funct3_in),
        .stOffset (ALUResult_in[1:0]),
        .isStore  (MemWrite_in),
        .stData   (rs2Data_in),
        .wdata    (alWdata),
        .wstrb    (alWstrb),
        .fault    (fault),
        .ldFunct3 (capFunct3),
        .ldOffset (capOff),
        .rdata    (capRdata),
        .loadData (loadData)
    );

    always_comb begin
        nextState     = state;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = 32'h0;
        dmem_wdata    = 32'h0;
        dmem_wstrb    = 4'h0;
        stall_mem     = 1'b0;
        misalign_mem  = 1'b0;
        bus_err_mem   = 1'b0;
        RegWrite_mem  = RegWrite_in;
        MemtoReg_mem  = MemtoReg_in;
        MemDout_mem   = 32'h0;
        ALUResult_mem = ALUResult_in;
        rdAddr_mem    = rdAddr_in;
        case (state)
            IDLE: begin
                if (access && fault) begin
                    misalign_mem = 1'b1;
                    RegWrite_mem = 1'b0;
                    MemtoReg_mem = 1'b0;
                end else if (access) begin
                    dmem_req     = 1'b1;
                    dmem_we      = MemWrite_in;
                    dmem_addr    = {ALUResult_in[31:2], 2'b00};
                    dmem_wdata   = MemWrite_in ? alWdata : 32'h0;
                    dmem_wstrb   = MemWrite_in ? alWstrb : 4'h0;
                    stall_mem    = 1'b1;
                    RegWrite_mem = 1'b0;
                    MemtoReg_mem = 1'b0;
                    nextState    = dmem_ack ? DONE : WAIT;
                end
            end
            WAIT: begin
                dmem_req     = 1'b1;
                dmem_we      = capWe;
                dmem_addr    = capAddr;
                dmem_wdata   = capWdata;
                dmem_wstrb   = capWstrb;
                stall_mem    = 1'b1;
                RegWrite_mem = 1'b0;
                MemtoReg_mem = 1'b0;
                if (dmem_ack || cnt == LAST_CNT) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                RegWrite_mem = RegWrite_in & ~errQ;
                MemtoReg_mem = MemtoReg_in & ~errQ;
                MemDout_mem  = (capWe | errQ) ? 32'h0 : loadData;
                bus_err_mem  = errQ;
                nextState    = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (rst) begin
            nextState     = IDLE;
            dmem_req      = 1'b0;
            dmem_we       = 1'b0;
            dmem_addr     = 32'h0;
            dmem_wdata    = 32'h0;
            dmem_wstrb    = 4'h0;
            stall_mem     = 1'b0;
            misalign_mem  = 1'b0;
            bus_err_mem   = 1'b0;
            RegWrite_mem  = 1'b0;
            MemtoReg_mem  = 1'b0;
            MemDout_mem   = 32'h0;
            ALUResult_mem = 32'h0;
            rdAddr_mem    = 5'h0;
        end
    end

    // The request is frozen on leaving IDLE; WAIT never looks at the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            capAddr   <= 32'h0;
            capWdata  <= 32'h0;
            capRdata  <= 32'h0;
            capWstrb  <= 4'h0;
            capFunct3 <= 3'h0;
            capOff    <= 2'h0;
            capWe     <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && nextState != IDLE) begin
                capAddr   <= {ALUResult_in[31:2], 2'b00};
                capWe     <= MemWrite_in;
                capWdata  <= MemWrite_in ? alWdata : 32'h0;
                capWstrb  <= MemWrite_in ? alWstrb : 4'h0;
                capFunct3 <= funct3_in;
                capOff    <= ALUResult_in[1:0];
                capRdata  <= dmem_ack ? dmem_rdata : 32'h0;
                errQ      <= 1'b0;
                cnt       <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (dmem_ack) begin
                    capRdata <= dmem_rdata;
                end else if (cnt == LAST_CNT) begin
                    errQ <= 1'b1;
                end
            end
        end
    end

endmodule
